// File: rtl/mem_bus_pkg.sv
// Shared definitions for single-bus word-memory initiators (CPU master, cache, DMA).
package mem_bus_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StTurn,
    StErr
  } bus_state_e;

endpackage

// File: rtl/mem_bus_master.sv
// Initiator for the shared word-memory bus: turns valid/ready core requests into CS/WE/ADDR
// sequences, owns the tristate data bus and returns a one-cycle response pulse.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int unsigned DEPTH       = 128,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ,
  input  logic              REQ_WE,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_WDATA,
  output logic              REQ_RDY,
  output logic              RSP_VALID,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              RSP_ERR,
  output logic              CS,
  output logic              WE,
  output logic [ADDR_W-1:0] ADDR,
  inout  wire  [DATA_W-1:0] Mem_Bus
);

  localparam logic [ADDR_W-1:0] DepthLim = ADDR_W'(DEPTH);
  localparam logic [3:0]        WaitMax  = 4'(WAIT_STATES);

  bus_state_e        state_q, state_d;
  logic              cs_q, cs_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              drive_q, drive_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic addr_oob;
  logic wait_done;

  assign addr_oob  = (REQ_ADDR >= DepthLim);
  assign wait_done = (cnt_q >= WaitMax);
  assign REQ_RDY   = (state_q == StIdle);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (REQ) state_d = addr_oob ? StErr : StAccess;
      StAccess: if (wait_done) state_d = we_q ? StTurn : StIdle;
      StTurn:   state_d = StIdle;
      StErr:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    cs_d        = cs_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    drive_d     = drive_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (REQ && !addr_oob) begin
          cs_d    = 1'b1;
          we_d    = REQ_WE;
          addr_d  = REQ_ADDR;
          wdata_d = REQ_WDATA;
          drive_d = REQ_WE;
          cnt_d   = '0;
        end
      end
      StAccess: begin
        if (!wait_done) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          // ADDR is deliberately left holding the last address.
          rsp_valid_d = 1'b1;
          cs_d        = 1'b0;
          we_d        = 1'b0;
          drive_d     = 1'b0;
          if (!we_q) rsp_rdata_d = Mem_Bus;
        end
      end
      StErr: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        rsp_rdata_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      drive_q     <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      cs_q        <= cs_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      drive_q     <= drive_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign CS        = cs_q;
  assign WE        = we_q;
  assign ADDR      = addr_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_ERR   = rsp_err_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign Mem_Bus   = drive_q ? wdata_q : 'z;

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: two instances (0 and 2 wait states) each with a falling-edge memory.
module tb_mem_bus_master;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        req = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        w2 = 1'b0;

  logic        rdy0, rv0, err0, cs0, we0;
  logic [31:0] rd0, addr0;
  wire  [31:0] bus0;
  logic        rdy2, rv2, err2, cs2, we2;
  logic [31:0] rd2, addr2;
  wire  [31:0] bus2;

  always #5 CLK = ~CLK;

  mem_bus_master #(.DEPTH(128), .WAIT_STATES(0)) dut0 (
    .CLK(CLK), .RST_N(RST_N), .REQ(req && !w2), .REQ_WE(req_we), .REQ_ADDR(req_addr),
    .REQ_WDATA(req_wdata), .REQ_RDY(rdy0), .RSP_VALID(rv0), .RSP_RDATA(rd0), .RSP_ERR(err0),
    .CS(cs0), .WE(we0), .ADDR(addr0), .Mem_Bus(bus0)
  );

  mem_bus_master #(.DEPTH(128), .WAIT_STATES(2)) dut2 (
    .CLK(CLK), .RST_N(RST_N), .REQ(req && w2), .REQ_WE(req_we), .REQ_ADDR(req_addr),
    .REQ_WDATA(req_wdata), .REQ_RDY(rdy2), .RSP_VALID(rv2), .RSP_RDATA(rd2), .RSP_ERR(err2),
    .CS(cs2), .WE(we2), .ADDR(addr2), .Mem_Bus(bus2)
  );

  logic        rdy_m, rv_m, err_m, cs_m, we_m;
  logic [31:0] rd_m, addr_m;
  assign rdy_m  = w2 ? rdy2 : rdy0;
  assign rv_m   = w2 ? rv2 : rv0;
  assign err_m  = w2 ? err2 : err0;
  assign cs_m   = w2 ? cs2 : cs0;
  assign we_m   = w2 ? we2 : we0;
  assign rd_m   = w2 ? rd2 : rd0;
  assign addr_m = w2 ? addr2 : addr0;

  // Memory responders: update/present data on the falling edge.
  logic [31:0] ram0 [128];
  logic [31:0] ram2 [128];
  logic [31:0] mq0 = '0, mq2 = '0;
  bit          init_done = 1'b0;

  always @(negedge CLK) begin
    if (!init_done) begin
      for (int i = 0; i < 128; i++) begin
        ram0[i] <= 32'h1000_0000 + 32'(i);
        ram2[i] <= 32'h2000_0000 + 32'(i);
      end
      ram2[10]  <= 32'h1234_5678;
      init_done <= 1'b1;
    end else begin
      if (cs0 && we0 && addr0 < 128) ram0[addr0[6:0]] <= bus0;
      if (cs0 && !we0 && addr0 < 128) mq0 <= ram0[addr0[6:0]];
      if (cs2 && we2 && addr2 < 128) ram2[addr2[6:0]] <= bus2;
      if (cs2 && !we2 && addr2 < 128) mq2 <= ram2[addr2[6:0]];
    end
  end

  assign bus0 = (cs0 && !we0) ? mq0 : 'z;
  assign bus2 = (cs2 && !we2) ? mq2 : 'z;

  int rsp_cnt0 = 0;
  int viol = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) begin
    if (rv0) rsp_cnt0 <= rsp_cnt0 + 1;
    if ((we0 && !cs0) || (we2 && !cs2)) viol <= viol + 1;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_rdy(input string name);
    int g = 0;
    while (!rdy_m && g < 30) begin
      step();
      g++;
    end
    chk(name, {31'd0, rdy_m}, 32'd1);
  endtask

  typedef struct {
    bit          sel2;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
    int          exp_cs;
    bit          exp_rdy;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int lat, cs_cnt, c0, acc_prev;
    bit we_seen;

    vecs[0] = '{0, 1, 32'd3,   32'hDEAD_BEEF, 32'h0,         0, 1, 1, 0};
    vecs[1] = '{0, 0, 32'd3,   32'h0,         32'hDEAD_BEEF, 0, 1, 1, 1};
    vecs[2] = '{1, 0, 32'd10,  32'h0,         32'h1234_5678, 0, 3, 3, 1};
    vecs[3] = '{0, 0, 32'd128, 32'h0,         32'h0,         1, 1, 0, 1};
    vecs[4] = '{0, 1, 32'd127, 32'hA5A5_0F0F, 32'h0,         0, 1, 1, 0};
    vecs[5] = '{0, 0, 32'd127, 32'h0,         32'hA5A5_0F0F, 0, 1, 1, 1};
    vecs[6] = '{1, 1, 32'd20,  32'hCAFE_F00D, 32'h0,         0, 3, 3, 0};
    vecs[7] = '{1, 0, 32'd20,  32'h0,         32'hCAFE_F00D, 0, 3, 3, 1};
    vecs[8] = '{1, 0, 32'hFFFF_FFFF, 32'h0,   32'h0,         1, 1, 0, 1};
    vecs[9] = '{0, 0, 32'd10,  32'h0,         32'h1000_000A, 0, 1, 1, 1};

    // Reset state
    #12;
    chk("rst_cs", {31'd0, cs0}, 32'd0);
    chk("rst_we", {31'd0, we0}, 32'd0);
    chk("rst_addr", addr0, 32'd0);
    chk("rst_rsp_valid", {31'd0, rv0}, 32'd0);
    chk("rst_rsp_err", {31'd0, err0}, 32'd0);
    chk("rst_rsp_rdata", rd0, 32'd0);
    chk("rst_rdy", {31'd0, rdy0}, 32'd1);
    @(negedge CLK);
    RST_N = 1'b1;
    step();

    // Reset mid-write to addr 5, before the falling edge
    w2 = 0; req = 1; req_we = 1; req_addr = 32'd5; req_wdata = 32'h55AA_55AA;
    wait_rdy("mid_rst_rdy");
    step();
    req = 0;
    chk("mid_rst_cs_started", {31'd0, cs0}, 32'd1);
    c0 = rsp_cnt0;
    RST_N = 1'b0;
    #1;
    chk("mid_rst_cs", {31'd0, cs0}, 32'd0);
    chk("mid_rst_we", {31'd0, we0}, 32'd0);
    chk("mid_rst_addr", addr0, 32'd0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) step();
    chk("mid_rst_no_rsp", 32'(rsp_cnt0 - c0), 32'd0);
    chk("mid_rst_ram5", ram0[5], 32'h1000_0005);

    // Table-driven single transactions
    foreach (vecs[i]) begin
      w2 = vecs[i].sel2; req = 1; req_we = vecs[i].we;
      req_addr = vecs[i].addr; req_wdata = vecs[i].wdata;
      wait_rdy($sformatf("v%0d_rdy", i));
      step();
      req = 0;
      lat = 0; cs_cnt = 0; we_seen = 0;
      while (!rv_m && lat < 40) begin
        cs_cnt += int'(cs_m);
        we_seen |= we_m;
        step();
        lat++;
      end
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_cs_cycles", i), 32'(cs_cnt), 32'(vecs[i].exp_cs));
      chk($sformatf("v%0d_we_seen", i), {31'd0, we_seen}, {31'd0, vecs[i].we && !vecs[i].exp_err});
      chk($sformatf("v%0d_err", i), {31'd0, err_m}, {31'd0, vecs[i].exp_err});
      chk($sformatf("v%0d_rdy_at_rsp", i), {31'd0, rdy_m}, {31'd0, vecs[i].exp_rdy});
      chk($sformatf("v%0d_cs_at_rsp", i), {31'd0, cs_m}, 32'd0);
      if (!vecs[i].we) chk($sformatf("v%0d_rdata", i), rd_m, vecs[i].exp_rdata);
      if (!vecs[i].exp_err) chk($sformatf("v%0d_addr_hold", i), addr_m, vecs[i].addr);
      step();
      chk($sformatf("v%0d_pulse_end", i), {31'd0, rv_m}, 32'd0);
      chk($sformatf("v%0d_err_end", i), {31'd0, err_m}, 32'd0);
    end

    // Back-to-back reads, REQ held high
    w2 = 0; req = 1; req_we = 0; acc_prev = 0;
    for (int k = 0; k < 3; k++) begin
      req_addr = 32'(k);
      wait_rdy($sformatf("b2b%0d_rdy", k));
      if (k > 0) chk($sformatf("b2b%0d_spacing", k), 32'(cyc - acc_prev), 32'd2);
      acc_prev = cyc;
      step();
      chk($sformatf("b2b%0d_rdy_low", k), {31'd0, rdy0}, 32'd0);
      step();
      chk($sformatf("b2b%0d_valid", k), {31'd0, rv0}, 32'd1);
      chk($sformatf("b2b%0d_rdata", k), rd0, 32'h1000_0000 + 32'(k));
    end
    req = 0;
    step();
    chk("b2b_quiet", {31'd0, rv0}, 32'd0);

    // Request held through TURN
    w2 = 0; req = 1; req_we = 1; req_addr = 32'd40; req_wdata = 32'h0F0F_1234;
    wait_rdy("held_rdy");
    c0 = rsp_cnt0;
    step();
    req_we = 0;
    step();
    chk("held_wr_valid", {31'd0, rv0}, 32'd1);
    chk("held_turn_rdy", {31'd0, rdy0}, 32'd0);
    chk("held_turn_cs", {31'd0, cs0}, 32'd0);
    step();
    chk("held_idle_rdy", {31'd0, rdy0}, 32'd1);
    chk("held_idle_cs", {31'd0, cs0}, 32'd0);
    chk("held_idle_valid", {31'd0, rv0}, 32'd0);
    step();
    req = 0;
    chk("held_rd_cs", {31'd0, cs0}, 32'd1);
    chk("held_rd_we", {31'd0, we0}, 32'd0);
    step();
    chk("held_rd_valid", {31'd0, rv0}, 32'd1);
    chk("held_rd_data", rd0, 32'h0F0F_1234);
    repeat (4) step();
    chk("held_rsp_count", 32'(rsp_cnt0 - c0), 32'd2);

    chk("we_without_cs", 32'(viol), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
